regfile_dump_sequencer: RTL and testbench

- Debug-side controller that walks the decode-stage register file through its debug read port and streams every register out as bytes to the UART transmitter.
- Drives the register-file debug address (into the ID stage's i_mips_register_number), samples the returned data (from o_mips_register_data), and serialises it LSB byte first over a valid/ready byte interface.
- Started by the debug unit on a one-cycle request; reports busy/done.

---
 rtl/regfile_dump_sequencer.sv | 143 ++++++++++++++
 tb/tb_regfile_dump_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_sequencer.sv
// Walks the register file through its debug read port and streams each register
// out LSB byte first on a valid/ready byte interface towards the UART transmitter.
module regfile_dump_sequencer #(
   parameter int NB       = 32,
   parameter int REGS     = 5,
   parameter int NUM_REGS = 32,
   parameter int BYTE     = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [NB-1:0]     i_reg_data,
   input  logic              i_tx_ready,
   output logic [REGS-1:0]   o_reg_number,
   output logic [BYTE-1:0]   o_tx_data,
   output logic              o_tx_valid,
   output logic              o_busy,
   output logic              o_done
);

   localparam int BPR = NB / BYTE;
   localparam int BIW = (BPR > 1) ? $clog2(BPR) : 1;
   localparam logic [REGS-1:0] LAST_REG  = REGS'(NUM_REGS - 1);
   localparam logic [BIW-1:0]  LAST_BYTE = BIW'(BPR - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SET_ADDR = 3'd1,
      LATCH    = 3'd2,
      SEND     = 3'd3,
      NEXT     = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t            state_r, state_s;
   logic [REGS-1:0]   reg_idx_r, reg_idx_s;
   logic [REGS-1:0]   reg_number_r, reg_number_s;
   logic [BIW-1:0]    byte_idx_r, byte_idx_s;
   logic [NB-1:0]     shift_r, shift_s;
   logic [BYTE-1:0]   tx_data_r, tx_data_s;
   logic              tx_valid_r, tx_valid_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic              accept_s;

   // Next-state and next-output logic; outputs are derived from the next state so they can be registered
   always_comb begin
      state_s      = state_r;
      reg_idx_s    = reg_idx_r;
      byte_idx_s   = byte_idx_r;
      shift_s      = shift_r;
      accept_s     = tx_valid_r & i_tx_ready;
      case (state_r)
         IDLE: begin
            if (i_start) begin
               reg_idx_s = {REGS{1'b0}};
               state_s   = SET_ADDR;
            end else begin
               state_s   = IDLE;
            end
         end
         SET_ADDR: state_s = LATCH;
         LATCH: begin
            shift_s    = i_reg_data;
            byte_idx_s = {BIW{1'b0}};
            state_s    = SEND;
         end
         SEND: begin
            if (accept_s) begin
               shift_s    = shift_r >> BYTE;
               byte_idx_s = byte_idx_r + BIW'(1);
               if (byte_idx_r == LAST_BYTE) begin
                  state_s = NEXT;
               end else begin
                  state_s = SEND;
               end
            end else begin
               state_s = SEND;
            end
         end
         NEXT: begin
            if (reg_idx_r == LAST_REG) begin
               state_s   = DONE;
            end else begin
               reg_idx_s = reg_idx_r + REGS'(1);
               state_s   = SET_ADDR;
            end
         end
         DONE: state_s = IDLE;
         default: state_s = IDLE;
      endcase

      // The debug address only moves on entry to SET_ADDR, so it is stable through LATCH
      if (state_s == SET_ADDR) begin
         reg_number_s = reg_idx_s;
      end else begin
         reg_number_s = reg_number_r;
      end

      if (state_s == SEND) begin
         tx_valid_s = 1'b1;
         tx_data_s  = shift_s[BYTE-1:0];
      end else begin
         tx_valid_s = 1'b0;
         tx_data_s  = {BYTE{1'b0}};
      end

      busy_s = (state_s != IDLE);
      done_s = (state_s == DONE);
   end

   // State, datapath and output registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_r      <= IDLE;
         reg_idx_r    <= {REGS{1'b0}};
         reg_number_r <= {REGS{1'b0}};
         byte_idx_r   <= {BIW{1'b0}};
         shift_r      <= {NB{1'b0}};
         tx_data_r    <= {BYTE{1'b0}};
         tx_valid_r   <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         reg_idx_r    <= reg_idx_s;
         reg_number_r <= reg_number_s;
         byte_idx_r   <= byte_idx_s;
         shift_r      <= shift_s;
         tx_data_r    <= tx_data_s;
         tx_valid_r   <= tx_valid_s;
         busy_r       <= busy_s;
         done_r       <= done_s;
      end
   end

   assign o_reg_number = reg_number_r;
   assign o_tx_data    = tx_data_r;
   assign o_tx_valid   = tx_valid_r;
   assign o_busy       = busy_r;
   assign o_done       = done_r;

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// Bench for regfile_dump_sequencer: scoreboard on the byte stream, a cycle table for
// the stalled-ready case, and directed sequences for restart, reset and a small instance.
module tb_regfile_dump_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, ready;
   logic [31:0] reg_data;
   logic [4:0]  reg_number;
   logic [7:0]  tx_data;
   logic        tx_valid, busy, done;
   logic        data_mode;

   logic        start_s;
   logic        ready_s;
   logic [15:0] reg_data_s;
   logic [1:0]  reg_number_s;
   logic [7:0]  tx_data_s;
   logic        tx_valid_s, busy_s, done_s;

   int n_checks = 0;
   int n_pass   = 0;
   int regchg_bad = 0;

   typedef struct packed {
      logic [7:0] b;
      logic [4:0] r;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic       start;
      logic       ready;
      logic       exp_busy;
      logic       exp_valid;
      logic [7:0] exp_data;
   } vec_t;
   vec_t vt[14];

   always #5 clk = ~clk;

   assign reg_data   = (data_mode && reg_number == 5'd0) ? 32'h11223344
                                                        : {3'b000, reg_number, 8'hA5, 16'h0000};
   assign reg_data_s = {6'h2A, reg_number_s, 8'h3C};
   assign ready_s    = 1'b1;

   regfile_dump_sequencer dut (
      .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_reg_data(reg_data),
      .i_tx_ready(ready), .o_reg_number(reg_number), .o_tx_data(tx_data),
      .o_tx_valid(tx_valid), .o_busy(busy), .o_done(done)
   );

   regfile_dump_sequencer #(.NB(16), .REGS(2), .NUM_REGS(4), .BYTE(8)) dut_s (
      .i_clk(clk), .i_reset(rst_n), .i_start(start_s), .i_reg_data(reg_data_s),
      .i_tx_ready(ready_s), .o_reg_number(reg_number_s), .o_tx_data(tx_data_s),
      .o_tx_valid(tx_valid_s), .o_busy(busy_s), .o_done(done_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_expected(input bit special);
      logic [31:0] d;
      for (int r = 0; r < 32; r++) begin
         d = (special && r == 0) ? 32'h11223344 : {3'b000, 5'(r), 8'hA5, 16'h0000};
         for (int b = 0; b < 4; b++) sb_q.push_back({d[8*b +: 8], 5'(r)});
      end
   endtask

   // Scoreboard: every accepted byte is compared against the queue head
   logic [4:0] prev_reg = 5'd0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && tx_valid && ready) begin
         if (sb_q.size() == 0) begin
            check("sb_extra_byte", {24'h0, tx_data}, 32'hFFFFFFFF);
         end else begin
            e = sb_q.pop_front();
            check("sb_byte", {24'h0, tx_data}, {24'h0, e.b});
            check("sb_reg", {27'h0, reg_number}, {27'h0, e.r});
         end
      end
      if (reg_number != prev_reg) begin
         if (tx_valid || !(reg_number == prev_reg + 5'd1 || reg_number == 5'd0)) regchg_bad++;
      end
      prev_reg = reg_number;
   end

   // mode 1: ready tied high with exact timing checks; mode 0: random ready
   task automatic do_dump(input int mode, input bit extra, input int reset_at);
      int done_cnt = 0;
      int done_at  = -1;
      int busy_bad = 0;
      push_expected(1'b0);
      @(posedge clk); #1;
      start = 1'b1;
      ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("cycle0_idle", {31'h0, busy}, 32'h0);
      for (int c = 1; c <= 3000; c++) begin
         @(posedge clk); #1;
         start = extra && (c == 10 || c == 100 || c == 225);
         ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         if (c == reset_at) begin
            #3; rst_n = 1'b0; #1;
            check("rst_reg_number", {27'h0, reg_number}, 32'h0);
            check("rst_tx_data", {24'h0, tx_data}, 32'h0);
            check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
            check("rst_busy", {31'h0, busy}, 32'h0);
            check("rst_done", {31'h0, done}, 32'h0);
            sb_q.delete();
            start = 1'b0;
            return;
         end
         @(negedge clk);
         if (done) begin
            done_cnt++;
            done_at = c;
         end
         if (mode == 1 && busy != (c <= 225)) busy_bad++;
         if (done_cnt > 0 && c >= done_at + 10) break;
      end
      check("done_count", done_cnt, 1);
      if (mode == 1) begin
         check("done_cycle", done_at, 225);
         check("busy_window", busy_bad, 0);
      end
      check("sb_empty", sb_q.size(), 0);
   endtask

   initial begin
      int got_n, ds_cnt, ds_at, idle_bad, dc;
      logic [7:0] got[16];
      rst_n = 1'b0; start = 1'b0; ready = 1'b0; data_mode = 1'b0; start_s = 1'b0;

      for (int i = 0; i < 14; i++) begin
         vt[i].start     = (i == 0);
         vt[i].ready     = (i >= 8);
         vt[i].exp_busy  = (i >= 1);
         vt[i].exp_valid = (i >= 3 && i <= 11);
         case (i)
            9:       vt[i].exp_data = 8'h33;
            10:      vt[i].exp_data = 8'h22;
            11:      vt[i].exp_data = 8'h11;
            default: vt[i].exp_data = 8'h44;
         endcase
      end

      #2;
      check("reset_reg_number", {27'h0, reg_number}, 32'h0);
      check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("reset_tx_data", {24'h0, tx_data}, 32'h0);
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_done", {31'h0, done}, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      do_dump(1, 1'b0, 0);
      do_dump(1, 1'b1, 0);

      // Stalled ready on register 0 with a distinctive data word
      data_mode = 1'b1;
      push_expected(1'b1);
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         start = vt[i].start;
         ready = vt[i].ready;
         @(negedge clk);
         check($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, vt[i].exp_busy});
         check($sformatf("vec%0d_valid", i), {31'h0, tx_valid}, {31'h0, vt[i].exp_valid});
         if (vt[i].exp_valid)
            check($sformatf("vec%0d_data", i), {24'h0, tx_data}, {24'h0, vt[i].exp_data});
      end
      dc = 0;
      for (int c = 14; c < 400 && dc == 0; c++) begin
         @(posedge clk); #1;
         start = 1'b0; ready = 1'b1;
         @(negedge clk);
         if (done) dc = 1;
      end
      check("stall_done", dc, 1);
      repeat (3) @(posedge clk);
      check("stall_sb_empty", sb_q.size(), 0);
      data_mode = 1'b0;

      do_dump(0, 1'b0, 0);

      do_dump(1, 1'b0, 50);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle_bad = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (tx_valid || busy) idle_bad++;
      end
      check("post_reset_idle", idle_bad, 0);
      do_dump(1, 1'b0, 0);

      // Small instance: 4 registers of 16 bits
      got_n = 0; ds_cnt = 0; ds_at = -1;
      @(posedge clk); #1 start_s = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1 start_s = 1'b0;
         @(negedge clk);
         if (tx_valid_s) begin
            if (got_n < 16) got[got_n] = tx_data_s;
            got_n++;
         end
         if (done_s) begin
            ds_cnt++;
            ds_at = c;
         end
      end
      check("small_bytes", got_n, 8);
      check("small_done_cnt", ds_cnt, 1);
      check("small_done_cycle", ds_at, 21);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("small_r%0d_b0", k), {24'h0, got[2*k]}, 32'h3C);
         check($sformatf("small_r%0d_b1", k), {24'h0, got[2*k+1]}, {24'h0, 6'h2A, 2'(k)});
      end

      check("reg_number_changes", regchg_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
